// File: rtl/moore_seq_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package moore_seq_pkg;

  localparam int SEQ_W_DEF = 4;
  localparam int CNT_W_DEF = 4;
  localparam int GAP_W_DEF = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    GAP   = 3'd2,
    PAR   = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic calc_even_parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/seq_gen_shreg.sv
// Loadable rotating pattern register with a down-counting bit index; last_bit
// marks the LSB of the frame. The rotation restores the pattern after each frame.
module seq_gen_shreg
  import moore_seq_pkg::*;
#(
  parameter int SEQ_W = SEQ_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [SEQ_W-1:0] pattern,
  output logic             bit_out,
  output logic             last_bit
);

  localparam int IDX_W = $clog2(SEQ_W);

  logic [SEQ_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    shreg_d = shreg_q;
    idx_d   = idx_q;
    if (load) begin
      shreg_d = pattern;
      idx_d   = IDX_W'(SEQ_W - 1);
    end else if (shift) begin
      shreg_d = {shreg_q[SEQ_W-2:0], shreg_q[SEQ_W-1]};
      idx_d   = (idx_q == '0) ? IDX_W'(SEQ_W - 1) : idx_q - IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
    end
  end

  assign bit_out  = shreg_q[SEQ_W-1];
  assign last_bit = (idx_q == '0);

endmodule

// File: rtl/moore_seq_generator.sv
// Serial pattern transmitter: MSB-first frames repeated repeat_n times with optional gaps.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to every frame.
module moore_seq_generator
  import moore_seq_pkg::*;
#(
  parameter int   SEQ_W    = SEQ_W_DEF,
  parameter int   CNT_W    = CNT_W_DEF,
  parameter int   GAP_W    = GAP_W_DEF,
  parameter logic IDLE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEQ_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap_n,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rep_n_q, rep_n_d, rep_cnt_q, rep_cnt_d;
  logic [GAP_W-1:0] gap_n_q, gap_n_d, gap_cnt_q, gap_cnt_d;
  logic             out_q, out_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic             load, shift, frame_end, sh_bit, last_bit;

`ifdef SEQ_GEN_PARITY_EN
  logic par_q, par_d;
`endif

  seq_gen_shreg #(.SEQ_W(SEQ_W)) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .shift    (shift),
    .pattern  (pattern),
    .bit_out  (sh_bit),
    .last_bit (last_bit)
  );

  always_comb begin
    state_d   = state_q;
    rep_n_d   = rep_n_q;
    gap_n_d   = gap_n_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    load      = 1'b0;
    shift     = 1'b0;
    frame_end = 1'b0;
`ifdef SEQ_GEN_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        rep_n_d   = repeat_n;
        gap_n_d   = gap_n;
        rep_cnt_d = '0;
        load      = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
        par_d     = calc_even_parity(32'(pattern));
`endif
        state_d   = (repeat_n == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        shift = 1'b1;
`ifdef SEQ_GEN_PARITY_EN
        if (last_bit) state_d = PAR;
`else
        frame_end = last_bit;
`endif
      end
`ifdef SEQ_GEN_PARITY_EN
      PAR:  frame_end = 1'b1;
`endif
      GAP: begin
        if (gap_cnt_q == '0) state_d = SHIFT;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // rep_cnt counts completed frames; comparing before increment avoids wrap at max repeat_n.
    if (frame_end) begin
      rep_cnt_d = rep_cnt_q + CNT_W'(1);
      if (rep_cnt_q == rep_n_q - CNT_W'(1)) begin
        state_d = DONE;
      end else if (gap_n_q != '0) begin
        state_d   = GAP;
        gap_cnt_d = gap_n_q - GAP_W'(1);
      end else begin
        state_d = SHIFT;
      end
    end

    out_d   = IDLE_LVL;
    valid_d = 1'b0;
    busy_d  = (state_q != IDLE);
    done_d  = (state_q == DONE);
    if (state_q == SHIFT) begin
      out_d   = sh_bit;
      valid_d = 1'b1;
    end
`ifdef SEQ_GEN_PARITY_EN
    if (state_q == PAR) begin
      out_d   = par_q;
      valid_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rep_n_q   <= '0;
      gap_n_q   <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
      out_q     <= IDLE_LVL;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rep_n_q   <= rep_n_d;
      gap_n_q   <= gap_n_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
